// File: rtl/qpmm_out_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : qpmm_out_reduce
//  Description : Final reduction of QPMM products from [0,4P) to [0,P),
//                followed by a credit-controlled show-ahead result FIFO.
//                Optional range/overflow checking enabled by QRED_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module qpmm_out_reduce #(
    parameter int           W     = 256,
    parameter logic [W-1:0] P     = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int           DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         issue,
    output logic         can_issue,
    input  logic         in_valid,
    input  logic [W-1:0] in_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z
`ifdef QRED_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [W:0]    c_P1    = {1'b0, P};
    localparam logic [W:0]    c_P2    = c_P1 << 1;
    localparam logic [PW-1:0] c_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Stage 1: conditional subtraction of 2P, registered
    // ------------------------------------------------------------------
    logic [W:0]   w_in_ext;
    logic         w_in_ge2p;
    logic [W-1:0] w_z1;

    logic         r_v1;
    logic [W-1:0] r_z1;

    assign w_in_ext  = {1'b0, in_z};
    assign w_in_ge2p = (w_in_ext >= c_P2);
    assign w_z1      = w_in_ge2p ? W'(w_in_ext - c_P2) : in_z;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            r_z1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_z1 <= w_z1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: conditional subtraction of P; the FIFO slot is its register
    // ------------------------------------------------------------------
    logic [W:0]   w_z1_ext;
    logic         w_z1_gep;
    logic [W-1:0] w_z2;

    assign w_z1_ext = {1'b0, r_z1};
    assign w_z1_gep = (w_z1_ext >= c_P1);
    assign w_z2     = w_z1_gep ? W'(w_z1_ext - c_P1) : r_z1;

    // ------------------------------------------------------------------
    // Show-ahead FIFO with modulo-DEPTH pointers
    // ------------------------------------------------------------------
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a push on a full FIFO survives then
    assign w_push    = r_v1 && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_z2;
        end
    end

    assign out_z = out_valid ? r_mem[r_rptr] : '0;

    // ------------------------------------------------------------------
    // Credit counter: tracks issued operations not yet popped
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (issue && w_pop) begin
            r_cnt <= r_cnt;
        end else if (issue && (r_cnt != c_DEPTH)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_pop && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign can_issue = (r_cnt < c_DEPTH);

`ifdef QRED_CHECK_EN
    // ------------------------------------------------------------------
    // Sticky error: out-of-range input or push dropped on a full FIFO
    // ------------------------------------------------------------------
    localparam logic [W:0] c_P4 = c_P1 << 2;

    logic r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if ((in_valid && (w_in_ext >= c_P4)) || (r_v1 && w_full && !w_pop)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire
